// File: rtl/outport_rr_arbiter.sv
// rtl/outport_rr_arbiter.sv - per-output-port round-robin packet arbiter with credit gating
//
// Shares one crossbar output between NREQ input FIFOs. A grant is taken on a
// HEADER flit and held until the TAIL flit has been forwarded; forwarding is
// gated on a credit counter mirroring free slots in the downstream buffer.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-low reset
//   req            per-input request (routing unit selected this output)
//   empty          per-input FIFO empty flag
//   flit_type      head-of-FIFO flit type, input i in bits [3i+2:3i]
//   credit_in      one-cycle pulse, downstream freed one slot
//   rd_en          one-hot FIFO pop (combinational)
//   grant          registered one-hot crossbar select, zero when idle
//   valid_out      registered, flit present on the output link
//   credit_cnt     current credit count
//   busy           high while a packet owns the output
//   err_credit_ovf sticky credit overflow flag, cleared only by reset

module outport_rr_arbiter #(
  parameter int          NREQ    = 3,
  parameter int          CREDITS = 4,
  parameter int          CW      = 3,
  parameter logic [2:0]  HEADER  = 3'b001,
  parameter logic [2:0]  TAIL    = 3'b100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     empty,
  input  logic [3*NREQ-1:0]   flit_type,
  input  logic                credit_in,
  output logic [NREQ-1:0]     rd_en,
  output logic [NREQ-1:0]     grant,
  output logic                valid_out,
  output logic [CW-1:0]       credit_cnt,
  output logic                busy,
  output logic                err_credit_ovf
);

  localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0]   CRED_MAX = CW'(CREDITS);
  localparam logic [NREQ-1:0] ONE      = NREQ'(1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gidx;
  logic [NREQ-1:0] eligible;
  logic            found;
  logic [IW-1:0]   win;
  logic            fwd;
  logic            tail_fwd;
  logic [2:0]      g_type;
  logic [CW-1:0]   credit_nxt;
  logic            ovf_set;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req[i] & ~empty[i] & (flit_type[3*i +: 3] == HEADER);
    end
  end

  // Search starts just after the last released input, so that input has
  // lowest priority in the next arbitration.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign g_type   = flit_type[int'(gidx)*3 +: 3];
  assign fwd      = (state == ACTIVE) & ~empty[gidx] & (credit_cnt != '0);
  assign tail_fwd = fwd & (g_type == TAIL);
  assign rd_en    = fwd ? (ONE << gidx) : '0;
  assign busy     = (state == ACTIVE);

  // A credit returned alongside a forward cancels out. A return with the
  // counter already full is a downstream protocol error: hold and flag it.
  always_comb begin
    credit_nxt = credit_cnt;
    ovf_set    = 1'b0;
    case ({fwd, credit_in})
      2'b10:   credit_nxt = credit_cnt - CW'(1);
      2'b01: begin
        if (credit_cnt == CRED_MAX) ovf_set = 1'b1;
        else                        credit_nxt = credit_cnt + CW'(1);
      end
      default: credit_nxt = credit_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)    state_nxt = ACTIVE;
      ACTIVE:  if (tail_fwd) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant          <= '0;
      gidx           <= '0;
      rr_ptr         <= IW'(NREQ - 1);
      valid_out      <= 1'b0;
      credit_cnt     <= CRED_MAX;
      err_credit_ovf <= 1'b0;
    end else begin
      valid_out  <= fwd;
      credit_cnt <= credit_nxt;
      if (ovf_set) err_credit_ovf <= 1'b1;
      if (state == IDLE && found) begin
        grant <= ONE << win;
        gidx  <= win;
      end else if (tail_fwd) begin
        grant  <= '0;
        rr_ptr <= gidx;
      end
    end
  end

endmodule

// File: tb/tb_outport_rr_arbiter.sv
// tb/tb_outport_rr_arbiter.sv - self-checking bench for outport_rr_arbiter

module tb_outport_rr_arbiter;

  localparam int         N  = 3;
  localparam int         CR = 4;
  localparam int         CW = 3;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] P  = 3'b010;
  localparam logic [2:0] T  = 3'b100;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    empty = '1;
  logic [3*N-1:0]  flit_type = '0;
  logic            credit_in = 1'b0;
  logic [N-1:0]    rd_en;
  logic [N-1:0]    grant;
  logic            valid_out;
  logic [CW-1:0]   credit_cnt;
  logic            busy;
  logic            err_credit_ovf;

  outport_rr_arbiter #(.NREQ(N), .CREDITS(CR), .CW(CW), .HEADER(H), .TAIL(T)) dut (
    .clk(clk), .rst(rst), .req(req), .empty(empty), .flit_type(flit_type),
    .credit_in(credit_in), .rd_en(rd_en), .grant(grant), .valid_out(valid_out),
    .credit_cnt(credit_cnt), .busy(busy), .err_credit_ovf(err_credit_ovf)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Input FIFO contents (flit types only)
  logic [2:0] fq [N][$];

  // Reference model: owner of the output (-1 when idle), last released input
  int   owner, last, cred;
  bit   err, vout;
  logic [N-1:0] exp_grant, exp_rd;

  // Stimulus controls
  logic [N-1:0] req_v = '0;
  logic [N-1:0] bub   = '0;
  int           ci_mode = 0;   // 0 none, 1 always, 2 random return, 3 match forwards
  bit           rand_mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int i, input int len);
    fq[i].push_back(H);
    for (int k = 0; k < len - 2; k++) fq[i].push_back(P);
    fq[i].push_back(T);
  endtask

  task automatic model_reset();
    owner = -1; last = N - 1; cred = CR; err = 0; vout = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".grant"},  grant,          exp_grant);
    check({tag, ".rd_en"},  rd_en,          exp_rd);
    check({tag, ".valid"},  valid_out,      vout);
    check({tag, ".credit"}, credit_cnt,     cred);
    check({tag, ".busy"},   busy,           owner >= 0);
    check({tag, ".ovf"},    err_credit_ovf, err);
  endtask

  // One clock cycle: drive at the falling edge, check 1ns later, advance the
  // model at the rising edge.
  task automatic cycle(input string tag);
    bit fwd;
    bit got;
    logic [2:0] ft;
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        req_v[i] = (fq[i].size() > 0) ? ($urandom % 8 != 0) : ($urandom % 4 == 0);
        bub[i]   = ($urandom % 6 == 0);
      end
    end
    for (int i = 0; i < N; i++) begin
      empty[i] = (fq[i].size() == 0) || bub[i];
      flit_type[3*i +: 3] = (fq[i].size() > 0) ? fq[i][0] : P;
    end
    req = req_v;
    exp_grant = (owner < 0) ? '0 : N'(1 << owner);
    exp_rd    = (owner >= 0 && !empty[owner] && cred > 0) ? N'(1 << owner) : '0;
    case (ci_mode)
      1:       credit_in = 1'b1;
      2:       credit_in = (cred < CR) && ($urandom % 3 == 0);
      3:       credit_in = (exp_rd != '0);
      default: credit_in = 1'b0;
    endcase
    #1;
    check_outputs(tag);
    @(posedge clk);
    fwd = (exp_rd != '0);
    if (owner >= 0) begin
      if (fwd) begin
        ft = fq[owner].pop_front();
        if (ft == T) begin
          last  = owner;
          owner = -1;
        end
      end
    end else begin
      got = 0;
      for (int j = 1; j <= N; j++) begin
        int i;
        i = (last + j) % N;
        if (!got && req[i] && !empty[i] && flit_type[3*i +: 3] == H) begin
          owner = i;
          got   = 1;
        end
      end
    end
    cred = cred - int'(fwd) + int'(credit_in);
    if (cred > CR) begin
      cred = CR;
      err  = 1;
    end
    vout = fwd;
    @(negedge clk);
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  // Asynchronous reset asserted between clock edges; outputs are checked
  // before any clock edge occurs.
  task automatic do_reset(input bit keep_queues);
    #2 rst = 1'b0;
    #1;
    model_reset();
    exp_grant = '0;
    exp_rd    = '0;
    check_outputs("reset");
    #1 rst = 1'b1;
    credit_in = 1'b0;
    ci_mode = 0;
    bub = '0;
    req_v = '0;
    rand_mode = 0;
    if (!keep_queues) for (int i = 0; i < N; i++) fq[i].delete();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset(0);

    // Single packet, no contention
    push_pkt(1, 3);
    req_v = 3'b010;
    run("single", 6);
    ci_mode = 1;
    run("refill", 3);
    ci_mode = 0;
    run("refill_idle", 1);

    // Round-robin fairness from reset
    do_reset(0);
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_pkt(i, 2);
    req_v = 3'b111;
    ci_mode = 2;
    run("rr", 30);

    // Credit stall and single-credit release
    do_reset(0);
    push_pkt(0, 6);
    req_v = 3'b001;
    run("stall", 8);
    ci_mode = 1;
    run("stall_ci", 1);
    ci_mode = 0;
    run("stall_one", 3);
    ci_mode = 2;
    run("stall_drain", 20);

    // Simultaneous forward and credit return at credit_cnt=2
    do_reset(0);
    push_pkt(0, 2);
    req_v = 3'b001;
    run("pre_simul", 4);
    push_pkt(0, 6);
    ci_mode = 3;
    run("simul", 9);
    ci_mode = 0;

    // Empty bubble mid-packet with a competing header waiting
    do_reset(0);
    push_pkt(0, 4);
    push_pkt(2, 2);
    req_v = 3'b101;
    ci_mode = 2;
    run("bubble_pre", 4);
    bub = 3'b001;
    run("bubble", 2);
    bub = '0;
    run("bubble_post", 12);

    // Credit overflow, then asynchronous reset mid-packet
    do_reset(0);
    ci_mode = 1;
    run("ovf", 1);
    ci_mode = 0;
    run("ovf_hold", 1);
    push_pkt(1, 5);
    req_v = 3'b010;
    run("mid_pkt", 3);
    do_reset(1);
    req_v = 3'b010;
    run("orphan", 3);
    for (int i = 0; i < N; i++) fq[i].delete();

    // Randomized traffic
    do_reset(0);
    rand_mode = 1;
    ci_mode = 2;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (fq[i].size() < 8 && $urandom % 5 == 0) push_pkt(i, 2 + int'($urandom % 5));
      cycle("rand");
    end
    rand_mode = 0;
    bub = '0;
    req_v = 3'b111;
    run("drain", 150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/outport_rr_arbiter.md
Name: outport_rr_arbiter

Overview:
- Per-output-port packet arbiter for the 2D-mesh router. It sits between the input FIFOs and their routing units on one side, and one output port of the crossbar on the other.
- It shares the output between NREQ input ports using round-robin, with a packet-level lock: a grant is held from the `HEADER flit through the `TAIL flit.
- It gates forwarding on a credit counter that tracks free slots in the downstream input buffer.

Parameters:
- NREQ, 3, number of requesting input ports.
- CREDITS, 4, downstream buffer depth; reset value of the credit counter.
- CW, 3, credit counter width; must satisfy 2^CW > CREDITS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  req[i]=1: input i's routing unit selects this output port.
- empty  in  NREQ  empty[i]=1: input FIFO i has no flit.
- flit_type  in  3*NREQ  head-of-FIFO flit type of input i, in bits [3i+2:3i]; encodings `HEADER/`PAYLOAD/`TAIL from parameters.v.
- credit_in  in  1  one-cycle pulse: downstream freed one slot.
- rd_en  out  NREQ  one-hot FIFO pop; combinational.
- grant  out  NREQ  registered one-hot crossbar select; all zero when idle.
- valid_out  out  1  registered; flit present on the output link this cycle.
- credit_cnt  out  CW  current credit count.
- busy  out  1  1 in ACTIVE state.
- err_credit_ovf  out  1  sticky; set on credit overflow.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, grant=0, rr_ptr=NREQ-1, valid_out=0, credit_cnt=CREDITS, err_credit_ovf=0.
  - rd_en=0 follows from the reset state.
- Eligibility: input i is eligible iff req[i] & ~empty[i] & (flit_type_i==`HEADER).
- IDLE:
  - If any input is eligible, pick the first eligible input searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Next cycle: grant=onehot(winner), state=ACTIVE.
  - No pop happens in the arbitration cycle. Grant latency is 1 cycle after eligibility.
- ACTIVE, with g the granted index:
  - fwd = ~empty[g] & (credit_cnt!=0).
  - rd_en[g]=fwd; all other rd_en bits are 0.
  - valid_out <= fwd (one cycle after rd_en, aligned with the registered FIFO read data).
  - If fwd and flit_type_g==`TAIL: next state=IDLE, grant<=0, rr_ptr<=g.
  - req[g] and flit_type of other inputs are ignored while ACTIVE. The lock holds until TAIL is forwarded, even if req[g] drops.
- Back-to-back packets:
  - IDLE costs one cycle, so at most one packet starts every (length+1) cycles.
  - Releasing input g gives it lowest priority in the next arbitration.
- Credits:
  - credit_cnt_next = credit_cnt - fwd + credit_in.
  - fwd and credit_in in the same cycle: count unchanged.
  - credit_cnt==0: no pop, no valid_out. The flit stalls, grant holds, no timeout.
  - Overflow (credit_in=1, fwd=0, credit_cnt==CREDITS): counter holds at CREDITS and err_credit_ovf sets. It clears only on reset.
- A pop is never issued on an empty FIFO, nor with credit_cnt==0.
- A non-HEADER flit at the head of a non-granted FIFO is never eligible and never popped.
- Reset mid-packet: everything returns to reset values immediately. Any partial packet downstream is the system's concern.
- busy = (state==ACTIVE).

Test Plan:
- Single packet, no contention:
  - Stimulus: input 1 holds H,P,T; req=3'b010; CREDITS=4.
  - Response: grant=3'b010 at cycle+1. rd_en[1] pulses 3 consecutive cycles and valid_out follows each by 1. credit_cnt goes 4→1, then grant=0 and rr_ptr=1.
- Round-robin fairness:
  - Stimulus: inputs 0,1,2 each with 2-flit packets (H,T) requesting simultaneously from reset.
  - Response: grant order 0,1,2. With continued requests the order stays 0,1,2, each packet contiguous and never interleaved.
- Credit stall:
  - Stimulus: CREDITS=4, 6-flit packet, no credit_in.
  - Response: 4 pops, then rd_en=0 and grant held. A credit_in pulse gives exactly one more pop the next cycle.
- Simultaneous fwd and credit_in:
  - Stimulus: credit_cnt=2 with credit_in pulses every cycle during forwarding.
  - Response: credit_cnt stays 2 and there are no gaps in valid_out.
- Empty bubble mid-packet:
  - Stimulus: empty[g]=1 for 2 cycles between P and T.
  - Response: rd_en=0 and valid_out=0 for 2 cycles, grant held, other HEADER requests not granted.
- Overflow and async reset:
  - Stimulus: credit_in at credit_cnt=CREDITS.
  - Response: err_credit_ovf=1 and credit_cnt=4.
  - Then assert rst=0 mid-packet between clock edges: grant=0, valid_out=0, credit_cnt=4, err_credit_ovf=0 without waiting for a clock edge.
